// File: rtl/frame_collect_pkg.sv
// frame_collect_pkg: shared trace-frame sizes and counter widths
package frame_collect_pkg;
  localparam int FRAME_BYTES = 16;
  localparam int WORDS_PER_FRAME = 8;
  localparam int WORD_W = 16;
  localparam int FRAME_W = FRAME_BYTES * 8;
  localparam int IDX_W = $clog2(WORDS_PER_FRAME);
  localparam int DROP_W = 8;
endpackage

// File: rtl/frame_fifo.sv
// frame_fifo: show-ahead frame FIFO with a registered head output
module frame_fifo
  import frame_collect_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [FRAME_W-1:0]     data_i,
  input  logic                   pop_i,
  output logic                   push_ready_o,
  output logic                   valid_o,
  output logic [FRAME_W-1:0]     data_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0] level_q, level_d;
  logic [FRAME_W-1:0] head_q, head_d;
  logic pop, push;
  always_comb begin
    pop = pop_i && valid_o;
    push_ready_o = level_q != LW'(DEPTH) || pop;
    push = push_i && push_ready_o;
    rd_d = rd_q + AW'(pop);
    wr_d = wr_q + AW'(push);
    level_d = level_q + LW'(push) - LW'(pop);
    // once the FIFO drains to nothing, the head comes straight from the incoming frame
    head_d = (level_q == LW'(pop)) ? (push ? data_i : head_q) : mem_q[rd_d];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      level_q <= '0;
      head_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      level_q <= level_d;
      head_q <= head_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= data_i;
  end
  assign valid_o = level_q != '0;
  assign data_o = head_q;
  assign level_o = level_q;
endmodule

// File: rtl/frame_collect.sv
// frame_collect: assembles 16-bit TPIU halfwords into 128-bit frames and queues them
module frame_collect
  import frame_collect_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   WdAvail,
  input  logic [WORD_W-1:0]      PacketWd,
  input  logic                   PacketReset,
  output logic                   FrameValid,
  output logic [FRAME_W-1:0]     Frame,
  input  logic                   FrameReady,
  output logic [$clog2(DEPTH):0] Level,
  output logic                   Overflow,
  output logic [DROP_W-1:0]      DropCount
);
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FRAME_W-1:0] asm_q, asm_d;
  logic ovf_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic push, push_ready, drop;
  always_comb begin
    asm_d = asm_q;
    idx_d = PacketReset ? '0 : idx_q + IDX_W'(WdAvail);
    if (WdAvail && !PacketReset) asm_d[{idx_q, 4'b0} +: WORD_W] = PacketWd;
    push = WdAvail && !PacketReset && idx_q == IDX_W'(WORDS_PER_FRAME - 1);
    drop = push && !push_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      ovf_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      ovf_q <= drop;
      drop_cnt_q <= drop_cnt_q + DROP_W'(drop && drop_cnt_q != '1);
    end
  end
  always_ff @(posedge clk) asm_q <= asm_d;
  frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .data_i      ({PacketWd, asm_q[FRAME_W-WORD_W-1:0]}),
    .pop_i       (FrameReady),
    .push_ready_o(push_ready),
    .valid_o     (FrameValid),
    .data_o      (Frame),
    .level_o     (Level)
  );
  assign Overflow = ovf_q;
  assign DropCount = drop_cnt_q;
endmodule

// File: doc/frame_collect.md
FRAME_COLLECT -- requirements
Module: frame_collect

Interface
REQ-001 SHALL have parameter DEPTH, default 4, frame FIFO depth in 16-byte frames; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  system clock; one clock only, all ports synchronous to it.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port WdAvail  input  1  single-cycle strobe: PacketWd valid this cycle.
REQ-005 SHALL have port PacketWd  input  16  next halfword of TPIU frame data.
REQ-006 SHALL have port PacketReset  input  1  upstream resync: discard any partial frame.
REQ-007 SHALL have port FrameValid  output  1  a complete frame is presented on Frame.
REQ-008 SHALL have port Frame  output  128  presented 16-byte frame.
REQ-009 SHALL have port FrameReady  input  1  consumer accepts Frame when high together with FrameValid.
REQ-010 SHALL have port Level  output  $clog2(DEPTH)+1  frames currently held in FIFO.
REQ-011 SHALL have port Overflow  output  1  single-cycle pulse: a completed frame was dropped.
REQ-012 SHALL have port DropCount  output  8  saturating count of dropped frames.

Function
REQ-013 SHALL keep a halfword index 0..7; each WdAvail cycle writes PacketWd into assembly bits [16*idx+15:16*idx] and increments idx.
REQ-014 SHALL, on the WdAvail cycle where idx==7, complete the frame, wrap idx to 0, and request a FIFO push of the 8 assembled halfwords.
REQ-015 SHALL push the completed frame at the clock edge ending that cycle; with the FIFO empty, FrameValid SHALL be high and Frame SHALL show it in the next cycle (1-cycle latency).
REQ-016 SHALL, on PacketReset, set idx to 0 and discard the partial frame; frames already in the FIFO SHALL be retained.
REQ-017 SHALL give PacketReset priority over a coincident WdAvail; that word SHALL be discarded and idx SHALL become 0.
REQ-018 SHALL operate the FIFO as show-ahead: FrameValid = (Level!=0); Frame = oldest entry; Frame SHALL be held stable while FrameValid && !FrameReady.
REQ-019 SHALL pop exactly one frame per cycle in which FrameValid && FrameReady.
REQ-020 SHALL accept a push when Level<DEPTH, or when Level==DEPTH and a pop occurs in the same cycle.
REQ-021 SHALL keep Level unchanged on a simultaneous push and pop.
REQ-022 SHALL, when a push is refused, drop the new frame, leave FIFO contents intact, pulse Overflow for one cycle and increment DropCount, saturating at 255.
REQ-023 SHALL wrap read and write pointers modulo DEPTH; full/empty SHALL be derived from Level, not from pointer equality alone.
REQ-024 SHALL ignore FrameReady while FrameValid is low.

Reset
REQ-025 SHALL, while rst is high, set idx=0, Level=0, pointers=0, FrameValid=0, Overflow=0, DropCount=0, Frame=0.
REQ-026 SHALL, on rst asserted mid-frame or with FIFO non-empty, discard all partial and stored frames, and SHALL ignore WdAvail, PacketReset and FrameReady in that cycle.
REQ-027 SHALL leave FIFO storage RAM contents uninitialised; only the Frame output register SHALL reset.

Structure
REQ-028 SHALL place FRAME_BYTES=16, WORDS_PER_FRAME=8 and the DropCount width in the shared trace package.
REQ-029 SHALL implement storage as one sub-module, frame_fifo (show-ahead, DEPTH x 128, push/pop/level); index and assembly logic SHALL stay in frame_collect.

Verification
REQ-030 SHALL cover: 8 WdAvail words 0x0001..0x0008 with FrameReady=1 -> one cycle later FrameValid=1, Frame=0x0008_0007_..._0001; popped that cycle, Level returns to 0.
REQ-031 SHALL cover: 3 words, PacketReset, then 8 words 0xA000..0xA007 -> exactly one frame output, containing only the 0xA00x words.
REQ-032 SHALL cover: PacketReset coincident with the 8th word -> no frame pushed; idx=0; the next 8 words form a clean frame.
REQ-033 SHALL cover: FrameReady=0, DEPTH=4, 5 complete frames -> Level=4, one Overflow pulse, DropCount=1; then draining yields frames 1-4 in order.
REQ-034 SHALL cover: Level==DEPTH, 8th word arriving in the same cycle as FrameReady=1 -> push accepted, Level stays 4, no Overflow.
REQ-035 SHALL cover: rst asserted with Level=2 and idx=5 -> next cycle FrameValid=0, Level=0; 8 fresh words produce a frame 1 cycle after the 8th word.
